cart_bus_ctrl: RTL and testbench

Sequencer directly upstream of the cartridge header pin-mapping block. Turns single CPU/MMU memory requests into timed Game Boy cartridge bus cycles and drives that block's inputs: cart_address, the cart_data pair, cart_r_enable_l, cart_w_enable_l, cart_cs_sram_l and cart_reset_l. Returns read data to the requester. Handles one transaction at a time.

---
 rtl/cart_bus_ctrl_pkg.sv | 24 ++
 rtl/cart_bus_ctrl_reset_sync.sv | 24 ++
 rtl/cart_bus_ctrl.sv | 156 +++++++++++++++
 tb/tb_cart_bus_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_bus_ctrl_pkg.sv
// Shared types and constants for the cartridge bus sequencer.
package cart_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;

    localparam logic [15:0] SRAM_LO = 16'hA000;
    localparam logic [15:0] SRAM_HI = 16'hBFFF;

    localparam int DEF_SETUP_CYCLES  = 1;
    localparam int DEF_STROBE_CYCLES = 2;
    localparam int DEF_HOLD_CYCLES   = 1;

    localparam int CNT_W = 4;

    function automatic logic is_sram(input logic [15:0] addr);
        return (addr >= SRAM_LO) && (addr <= SRAM_HI);
    endfunction

endpackage

// File: rtl/cart_bus_ctrl_reset_sync.sv
// Cartridge reset generator: asserts asynchronously with reset_l and
// releases on the second clock edge after reset_l rises.
module cart_reset_sync (
    input  logic clock,
    input  logic reset_l,
    output logic cart_reset_l
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= 1'b1;
            sync_p1 <= sync_p0;
        end
    end

    assign cart_reset_l = sync_p1;

endmodule

// File: rtl/cart_bus_ctrl.sv
// Game Boy cartridge bus sequencer: one CPU request -> SETUP/STROBE/HOLD bus cycle.
// Optional macro CART_DATA_SYNC_EN adds a 2-stage input register on cart_data_in.
module cart_bus_ctrl
    import cart_bus_pkg::*;
#(
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
    input  logic        clock,
    input  logic        reset_l,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic [15:0] cart_address,
    output logic [7:0]  cart_data_out,
    output logic        cart_data_oe,
    input  logic [7:0]  cart_data_in,
    output logic        cart_r_enable_l,
    output logic        cart_w_enable_l,
    output logic        cart_cs_sram_l,
    output logic        cart_reset_l
);

`ifdef CART_DATA_SYNC_EN
    localparam int SYNC_EXTRA = 2;
`else
    localparam int SYNC_EXTRA = 0;
`endif

    localparam logic [CNT_W-1:0] SETUP_LD     = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_WR_LD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_RD_LD = CNT_W'(STROBE_CYCLES + SYNC_EXTRA - 1);
    localparam logic [CNT_W-1:0] HOLD_LD      = CNT_W'(HOLD_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             we_q, hit_q;
    logic             accept, capture, active, we_nxt;
    logic             cs_l_nxt, oe_nxt, r_l_nxt, w_l_nxt;
    logic [7:0]       sample_data;

    cart_reset_sync u_reset_sync (
        .clock        (clock),
        .reset_l      (reset_l),
        .cart_reset_l (cart_reset_l)
    );

`ifdef CART_DATA_SYNC_EN
    logic [7:0] data_in_p0;
    logic [7:0] data_in_p1;

    // Input sync stages p0 -> p1; the read STROBE is stretched to cover them.
    always_ff @(posedge clock) begin
        data_in_p0 <= cart_data_in;
        data_in_p1 <= data_in_p0;
    end

    assign sample_data = data_in_p1;
`else
    assign sample_data = cart_data_in;
`endif

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt = ST_SETUP;
                    cnt_nxt   = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_nxt = ST_STROBE;
                    cnt_nxt   = we_q ? STROBE_WR_LD : STROBE_RD_LD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_STROBE: begin
                if (cnt == '0) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = HOLD_LD;
                    capture   = !we_q;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Pin values are decoded from the upcoming state so every pin leaves a flop.
        we_nxt   = accept ? req_we : we_q;
        active   = (state_nxt != ST_IDLE);
        cs_l_nxt = !(active && (accept ? is_sram(req_addr) : hit_q));
        oe_nxt   = active && we_nxt;
        r_l_nxt  = !(!we_nxt && ((state_nxt == ST_SETUP) || (state_nxt == ST_STROBE)));
        w_l_nxt  = !(we_nxt && (state_nxt == ST_STROBE));
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            we_q            <= 1'b0;
            hit_q           <= 1'b0;
            cart_address    <= '0;
            cart_data_out   <= '0;
            cart_data_oe    <= 1'b0;
            cart_r_enable_l <= 1'b1;
            cart_w_enable_l <= 1'b1;
            cart_cs_sram_l  <= 1'b1;
            rd_valid        <= 1'b0;
            rd_data         <= '0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            cart_data_oe    <= oe_nxt;
            cart_r_enable_l <= r_l_nxt;
            cart_w_enable_l <= w_l_nxt;
            cart_cs_sram_l  <= cs_l_nxt;
            rd_valid        <= capture;
            if (accept) begin
                we_q          <= req_we;
                hit_q         <= is_sram(req_addr);
                cart_address  <= req_addr;
                cart_data_out <= req_wdata;
            end
            if (capture) begin
                rd_data <= sample_data;
            end
        end
    end

endmodule

// File: tb/tb_cart_bus_ctrl.sv
// Scoreboard bench for cart_bus_ctrl: directed requests, queued expectations, negedge monitor.
module tb_cart_bus_ctrl;

`ifdef CART_DATA_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic        clock;
    logic        reset_l;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic [15:0] cart_address;
    logic [7:0]  cart_data_out;
    logic        cart_data_oe;
    logic [7:0]  cart_data_in;
    logic        cart_r_enable_l;
    logic        cart_w_enable_l;
    logic        cart_cs_sram_l;
    logic        cart_reset_l;

    cart_bus_ctrl dut (
        .clock           (clock),
        .reset_l         (reset_l),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .cart_address    (cart_address),
        .cart_data_out   (cart_data_out),
        .cart_data_oe    (cart_data_oe),
        .cart_data_in    (cart_data_in),
        .cart_r_enable_l (cart_r_enable_l),
        .cart_w_enable_l (cart_w_enable_l),
        .cart_cs_sram_l  (cart_cs_sram_l),
        .cart_reset_l    (cart_reset_l)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // {oe expected, cs_l expected, address}
    logic [17:0] exp_bus[$];
    logic [7:0]  exp_rd[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                         input logic cs_l, input bit keep);
        int t;
        t = 0;
        while (!req_ready && t < 64) begin
            @(negedge clock);
            t++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL issue_timeout: req_ready stuck at 0, expected 1");
        end
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        exp_bus.push_back({we, cs_l, addr});
        @(posedge clock);
        @(negedge clock);
        if (!keep) req_valid = 1'b0;
    endtask

    // Monitor: bus-cycle start, read returns, and strobe/oe ordering.
    initial begin
        bit          prev_ready;
        logic [17:0] eb;
        logic [7:0]  er;
        prev_ready = 1'b1;
        forever begin
            @(negedge clock);
            if (prev_ready && !req_ready) begin
                if (exp_bus.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL bus_unexpected: cycle at 0x%0h, expected none", cart_address);
                end else begin
                    eb = exp_bus.pop_front();
                    check("bus_addr", cart_address, eb[15:0]);
                    check("bus_cs", cart_cs_sram_l, eb[16]);
                    check("bus_oe", cart_data_oe, eb[17]);
                end
            end
            prev_ready = req_ready;
            if (rd_valid) begin
                if (exp_rd.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rd_unexpected: rd_valid with data 0x%0h, expected no pulse", rd_data);
                end else begin
                    er = exp_rd.pop_front();
                    check("rd_data", rd_data, er);
                end
            end
            if (reset_l) begin
                check("strobe_excl", cart_r_enable_l | cart_w_enable_l, 1);
                check("oe_vs_read", cart_data_oe & ~cart_r_enable_l, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [15:0] baddr [4];
        logic        bcs   [4];
        reset_l      = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        cart_data_in = '0;
        repeat (3) @(negedge clock);

        check("rst_req_ready", req_ready, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_address", cart_address, 0);
        check("rst_data_out", cart_data_out, 0);
        check("rst_oe", cart_data_oe, 0);
        check("rst_r_en", cart_r_enable_l, 1);
        check("rst_w_en", cart_w_enable_l, 1);
        check("rst_cs", cart_cs_sram_l, 1);
        check("rst_cart_reset", cart_reset_l, 0);

        #2 reset_l = 1'b1;
        @(negedge clock);
        check("cart_reset_edge1", cart_reset_l, 0);
        @(negedge clock);
        check("cart_reset_edge2", cart_reset_l, 1);
        check("ready_after_reset", req_ready, 1);

        // Write 0x5A to SRAM 0xA123; cycles k=1..5 after the accept edge.
        issue(1'b1, 16'hA123, 8'h5A, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("wr_w_en_k%0d", k), cart_w_enable_l, (k == 2 || k == 3) ? 0 : 1);
            check($sformatf("wr_r_en_k%0d", k), cart_r_enable_l, 1);
            check($sformatf("wr_ready_k%0d", k), req_ready, (k == 5) ? 1 : 0);
            check($sformatf("wr_cs_k%0d", k), cart_cs_sram_l, (k == 5) ? 1 : 0);
            check($sformatf("wr_oe_k%0d", k), cart_data_oe, (k == 5) ? 0 : 1);
            if (k <= 4) check($sformatf("wr_data_k%0d", k), cart_data_out, 8'h5A);
            if (k < 5) @(negedge clock);
        end

        // Read 0x4000 (not SRAM) with 0xC3 on the pins.
        cart_data_in = 8'hC3;
        exp_rd.push_back(8'hC3);
        issue(1'b0, 16'h4000, 8'h00, 1'b1, 1'b0);
        for (int k = 1; k <= 5 + EXTRA; k++) begin
            check($sformatf("rd_r_en_k%0d", k), cart_r_enable_l, (k <= 3 + EXTRA) ? 0 : 1);
            check($sformatf("rd_w_en_k%0d", k), cart_w_enable_l, 1);
            check($sformatf("rd_cs_k%0d", k), cart_cs_sram_l, 1);
            check($sformatf("rd_oe_k%0d", k), cart_data_oe, 0);
            check($sformatf("rd_valid_k%0d", k), rd_valid, (k == 4 + EXTRA) ? 1 : 0);
            check($sformatf("rd_ready_k%0d", k), req_ready, (k == 5 + EXTRA) ? 1 : 0);
            if (k < 5 + EXTRA) @(negedge clock);
        end
        check("rd_data_held", rd_data, 8'hC3);

        // SRAM window edges, checked by the bus monitor.
        baddr[0] = 16'h9FFF; bcs[0] = 1'b1;
        baddr[1] = 16'hA000; bcs[1] = 1'b0;
        baddr[2] = 16'hBFFF; bcs[2] = 1'b0;
        baddr[3] = 16'hC000; bcs[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, baddr[i], 8'h10 + 8'(i), bcs[i], 1'b0);
        end

        // Busy: req_valid stays high and the address changes mid-transaction.
        cart_data_in = 8'h3C;
        exp_rd.push_back(8'h3C);
        exp_rd.push_back(8'h3C);
        issue(1'b0, 16'h1111, 8'h00, 1'b1, 1'b1);
        req_addr = 16'h2222;
        exp_bus.push_back({1'b0, 1'b1, 16'h2222});
        c = 1;
        while (!req_ready && c < 64) begin
            @(negedge clock);
            c++;
        end
        check("busy_ready_cycle", c, 5 + EXTRA);
        check("busy_addr_held", cart_address, 16'h1111);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        check("busy_second_addr", cart_address, 16'h2222);
        c = 0;
        while (!req_ready && c < 64) begin
            @(negedge clock);
            c++;
        end

        // Abort a read during STROBE.
        cart_data_in = 8'h99;
        issue(1'b0, 16'h0100, 8'h00, 1'b1, 1'b0);
        @(negedge clock);
        check("abort_in_strobe", cart_r_enable_l, 0);
        #2 reset_l = 1'b0;
        #1;
        check("abort_r_en", cart_r_enable_l, 1);
        check("abort_w_en", cart_w_enable_l, 1);
        check("abort_cs", cart_cs_sram_l, 1);
        check("abort_oe", cart_data_oe, 0);
        check("abort_rd_valid", rd_valid, 0);
        check("abort_rd_data", rd_data, 0);
        check("abort_cart_reset", cart_reset_l, 0);
        check("abort_ready", req_ready, 1);
        repeat (3) @(negedge clock);
        #2 reset_l = 1'b1;
        @(negedge clock);
        check("abort_cart_reset_edge1", cart_reset_l, 0);
        @(negedge clock);
        check("abort_cart_reset_edge2", cart_reset_l, 1);
        repeat (6) @(negedge clock);
        check("abort_rd_data_after", rd_data, 0);

        check("bus_queue_empty", exp_bus.size(), 0);
        check("rd_queue_empty", exp_rd.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
